fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 AWIDTH, 32, address/PC width in bits.
REQ-002 INITIAL_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_redirect  input  1  redirect request (branch/jump resolved).
REQ-006 i_redirect_pc  input  AWIDTH  redirect target, word-aligned.
REQ-007 o_mem_rq  output  1  instruction-memory request valid.
REQ-008 o_mem_addr  output  AWIDTH  request address, stable while o_mem_rq=1 and i_mem_ack=0.
REQ-009 i_mem_ack  input  1  request accepted; data returned same cycle.
REQ-010 i_mem_data  input  32  instruction word, valid when i_mem_ack=1.
REQ-011 o_inst_valid  output  1  fetch queue head valid.
REQ-012 o_inst  output  32  head instruction.
REQ-013 o_inst_pc  output  AWIDTH  PC of head instruction.
REQ-014 i_inst_ready  input  1  decode accepts head; pop when o_inst_valid&i_inst_ready.

Function
REQ-015 Fetch queue: 2-entry FIFO of {pc, inst}; push on i_mem_ack in FETCH state, pop on decode handshake.
REQ-016 FSM states: IDLE, FETCH, DRAIN.
REQ-017 IDLE: entered from reset; moves to FETCH next cycle with fetch_pc=INITIAL_PC.
REQ-018 FETCH: o_mem_rq=1 iff queue not full, or a pop occurs in the same cycle; o_mem_addr=fetch_pc.
REQ-019 On i_mem_ack in FETCH without redirect: push {fetch_pc, i_mem_data}; fetch_pc+=4 modulo 2^AWIDTH (32'hFFFF_FFFC wraps to 0).
REQ-020 Simultaneous push and pop on full queue: both occur; occupancy unchanged.
REQ-021 Redirect (any state): queue flushed same edge, fetch_pc=i_redirect_pc, ack in that cycle discarded; next state FETCH.
REQ-022 Redirect with o_mem_rq=1 and i_mem_ack=0: request withdrawn; next state DRAIN for exactly one cycle with o_mem_rq=0, then FETCH.
REQ-023 Redirect has priority over push/pop; o_inst_valid=0 the cycle after redirect.
REQ-024 Latency: redirect at edge N -> o_mem_addr=i_redirect_pc with o_mem_rq=1 at cycle N+1 (no pending request) or N+2 (via DRAIN); ack at cycle M -> o_inst_valid=1 at M+1.
REQ-025 o_mem_rq never asserted when it would overflow the queue; at most one request in flight.
REQ-026 o_inst/o_inst_pc are don't-care while o_inst_valid=0.

Reset
REQ-027 i_reset=1: state=IDLE, queue empty, fetch_pc=INITIAL_PC, o_mem_rq=0, o_inst_valid=0, o_mem_addr=INITIAL_PC, o_inst=0, o_inst_pc=0.
REQ-028 Reset mid-request or mid-DRAIN: outstanding request abandoned, no push; reset overrides redirect.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN defined: adds outputs o_fetch_cnt (32) counting accepted acks and o_stall_cnt (32) counting cycles o_mem_rq=0 in FETCH; both reset to 0, wrap at 2^32.
REQ-030 FETCH_PERF_CNT_EN undefined: these ports and counters absent; all other behaviour identical.

Verification
REQ-031 Reset release, ack every cycle, ready=1 -> o_inst_pc sequence 0x0,0x4,0x8 on consecutive cycles from cycle 3.
REQ-032 ready=0, ack=1 always -> two pushes (0x0,0x4), then o_mem_rq=0 holding addr 0x8; ready=1 pops 0x0 and same cycle o_mem_rq=1.
REQ-033 Redirect to 0x100 with queue full -> next cycle o_inst_valid=0, o_mem_addr=0x100, o_mem_rq=1.
REQ-034 Redirect to 0x200 while o_mem_rq=1, ack=0 -> one DRAIN cycle with o_mem_rq=0, then o_mem_addr=0x200.
REQ-035 Redirect to 0xFFFF_FFFC, two acks -> o_inst_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-036 i_reset asserted with queue full and request pending -> next cycle o_inst_valid=0, o_mem_rq=0; FETCH resumes at INITIAL_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: IDLE/FETCH/DRAIN FSM feeding a 2-entry fetch queue.
// Optional perf counters o_fetch_cnt/o_stall_cnt when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl #(
  parameter int unsigned AWIDTH = 32,
  parameter logic [AWIDTH-1:0] INITIAL_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_redirect,
  input  logic [AWIDTH-1:0] i_redirect_pc,
  output logic              o_mem_rq,
  output logic [AWIDTH-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_data,
  output logic              o_inst_valid,
  output logic [31:0]       o_inst,
  output logic [AWIDTH-1:0] o_inst_pc,
  input  logic              i_inst_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       o_fetch_cnt,
  output logic [31:0]       o_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t            state;
  logic [AWIDTH-1:0] fetch_pc;
  logic [AWIDTH-1:0] q_pc   [2];
  logic [31:0]       q_inst [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;

  logic full;
  logic pop;
  logic push;

  assign full         = (count == 2'd2);
  assign o_inst_valid = (count != 2'd0);
  assign pop          = o_inst_valid & i_inst_ready;

  // A pop frees a slot the same cycle, so a full queue may still request.
  assign o_mem_rq = ~i_reset & (state == FETCH) & (~full | pop);
  assign push     = o_mem_rq & i_mem_ack & ~i_redirect;

  assign o_mem_addr = fetch_pc;
  assign o_inst     = q_inst[rd_ptr];
  assign o_inst_pc  = q_pc[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      fetch_pc <= INITIAL_PC;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
    end else if (i_redirect) begin
      // An unanswered request is withdrawn; hold off one cycle before reissuing.
      state    <= (o_mem_rq & ~i_mem_ack) ? DRAIN : FETCH;
      fetch_pc <= i_redirect_pc;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          state    <= FETCH;
          fetch_pc <= INITIAL_PC;
        end
        DRAIN: begin
          state <= FETCH;
        end
        FETCH: begin
          if (push) begin
            q_pc[wr_ptr]   <= fetch_pc;
            q_inst[wr_ptr] <= i_mem_data;
            wr_ptr         <= ~wr_ptr;
            fetch_pc       <= fetch_pc + AWIDTH'(4);
          end
          if (pop) begin
            rd_ptr <= ~rd_ptr;
          end
          count <= count + {1'b0, push} - {1'b0, pop};
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_fetch_cnt <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (push) begin
        o_fetch_cnt <= o_fetch_cnt + 32'd1;
      end
      if (state == FETCH && !o_mem_rq) begin
        o_stall_cnt <= o_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal checks, then
// randomized traffic compared each cycle against a queue-based model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        redir;
  logic [31:0] rpc;
  logic        rq;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;
  logic        ivalid;
  logic [31:0] inst;
  logic [31:0] ipc;
  logic        ready;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_ctrl #(.AWIDTH(32), .INITIAL_PC(32'h0)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_redirect   (redir),
    .i_redirect_pc(rpc),
    .o_mem_rq     (rq),
    .o_mem_addr   (addr),
    .i_mem_ack    (ack),
    .i_mem_data   (data),
    .o_inst_valid (ivalid),
    .o_inst       (inst),
    .o_inst_pc    (ipc),
    .i_inst_ready (ready)
  );

  always #5 clk = ~clk;

  // Model: mode 0 = waiting after reset, 1 = fetching, 2 = one-cycle holdoff
  int          mode;
  logic [31:0] mq_pc[$];
  logic [31:0] mq_inst[$];
  logic [31:0] mpc;
  logic        m_rq;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    m_rq = (mode == 1) && !rst &&
           (mq_pc.size() < 2 || (mq_pc.size() > 0 && ready));
    chk("rq", {31'b0, rq}, {31'b0, m_rq});
    if (m_rq) chk("addr", addr, mpc);
    chk("valid", {31'b0, ivalid}, {31'b0, mq_pc.size() > 0});
    if (mq_pc.size() > 0) begin
      chk("inst_pc", ipc, mq_pc[0]);
      chk("inst", inst, mq_inst[0]);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst) begin
      mode = 0;
      mq_pc.delete();
      mq_inst.delete();
      mpc = 32'h0;
    end else if (redir) begin
      mq_pc.delete();
      mq_inst.delete();
      mode = (m_rq && !ack) ? 2 : 1;
      mpc  = rpc;
    end else if (mode != 1) begin
      mode = 1;
    end else begin
      if (mq_pc.size() > 0 && ready) begin
        void'(mq_pc.pop_front());
        void'(mq_inst.pop_front());
      end
      if (m_rq && ack) begin
        mq_pc.push_back(mpc);
        mq_inst.push_back(data);
        mpc = mpc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  task automatic drive(input logic r, input logic d, input logic [31:0] p,
                       input logic a, input logic rd);
    rst   = r;
    redir = d;
    rpc   = p;
    ack   = a;
    ready = rd;
    data  = $urandom;
  endtask

  initial begin
    mode = 0;
    mpc  = 32'h0;
    m_rq = 1'b0;
    drive(1, 0, 0, 0, 0);
    settle();
    chk("rst_rq", {31'b0, rq}, 32'h0);
    chk("rst_valid", {31'b0, ivalid}, 32'h0);
    adv();
    settle();
    chk("rst_addr", addr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_ipc", ipc, 32'h0);
    adv();

    // Streaming: ack and ready every cycle
    drive(0, 0, 0, 1, 1);
    tick();
    drive(0, 0, 0, 1, 1);
    tick();
    drive(0, 0, 0, 1, 1);
    settle();
    chk("stream0", ipc, 32'h0);
    adv();
    drive(0, 0, 0, 1, 1);
    settle();
    chk("stream4", ipc, 32'h4);
    adv();
    drive(0, 0, 0, 1, 1);
    settle();
    chk("stream8", ipc, 32'h8);
    adv();

    // Back-pressure: fill then pop with same-cycle request
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    tick();
    tick();
    tick();
    drive(0, 0, 0, 1, 0);
    settle();
    chk("full_rq", {31'b0, rq}, 32'h0);
    chk("full_addr", addr, 32'h8);
    chk("full_head", ipc, 32'h0);
    adv();
    drive(0, 0, 0, 1, 1);
    settle();
    chk("pop_rq", {31'b0, rq}, 32'h1);
    chk("pop_head", ipc, 32'h0);
    adv();

    // Redirect with queue full (no request pending)
    drive(0, 1, 32'h100, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    settle();
    chk("rd1_valid", {31'b0, ivalid}, 32'h0);
    chk("rd1_addr", addr, 32'h100);
    chk("rd1_rq", {31'b0, rq}, 32'h1);
    adv();

    // Redirect while request pending without ack -> drain
    drive(0, 1, 32'h200, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    settle();
    chk("drain_rq", {31'b0, rq}, 32'h0);
    adv();
    drive(0, 0, 0, 0, 0);
    settle();
    chk("post_drain_rq", {31'b0, rq}, 32'h1);
    chk("post_drain_addr", addr, 32'h200);
    adv();

    // Address wrap
    drive(0, 1, 32'hFFFF_FFFC, 1, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    tick();
    tick();
    drive(0, 0, 0, 0, 1);
    settle();
    chk("wrap_hi", ipc, 32'hFFFF_FFFC);
    adv();
    drive(0, 0, 0, 0, 0);
    settle();
    chk("wrap_lo", ipc, 32'h0);
    adv();

    // Reset with queue full and a request pending
    drive(0, 0, 0, 1, 0);
    tick();
    drive(1, 0, 0, 0, 1);
    settle();
    chk("rstmid_rq_before", {31'b0, rq}, 32'h0);
    adv();
    drive(0, 0, 0, 0, 0);
    settle();
    chk("rstmid_valid", {31'b0, ivalid}, 32'h0);
    chk("rstmid_rq", {31'b0, rq}, 32'h0);
    adv();
    settle();
    chk("resume_rq", {31'b0, rq}, 32'h1);
    chk("resume_addr", addr, 32'h0);
    adv();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      logic [31:0] p;
      p = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) p = 32'hFFFF_FFF8;
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 11) == 0, p,
            $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
